// File: rtl/sum_rd_quant_if.sv
// Output stream bundle of sum_rd_quant: FWFT FIFO head toward the output buffer writer.
// Ports: dout (data word), dv (valid), rdy (downstream ready); master drives dout/dv.
interface sum_rd_quant_if #(
    parameter int C_OSIZE = 8
);
    logic [C_OSIZE-1:0] dout;
    logic               dv;
    logic               rdy;

    modport master (output dout, output dv, input rdy);
    modport slave  (input dout, input dv, output rdy);
endinterface

// File: rtl/sum_rd_quant.sv
// Sum RAM read-out: reads len partial sums in address order, adds bias, shifts,
// optional ReLU, saturates to C_OSIZE and streams them through a credit-throttled FWFT FIFO.
// Ports: I_clk/I_rst (sync, active-high), I_start/I_len/I_bias/I_shift/I_relu_en (run setup),
// O_raddr/I_rdata (sum RAM read port), obuf (dout/dv/rdy stream), O_busy, O_done.
// Build option: define SUM_RD_QUANT_ROUND_EN for round-half-up before the shift.
module sum_rd_quant #(
    parameter int C_DSIZE      = 24,
    parameter int C_ASIZE      = 10,
    parameter int C_OSIZE      = 8,
    parameter int C_SSIZE      = 5,
    parameter int C_RD_LAT     = 3,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_start,
    input  logic [C_ASIZE:0]          I_len,
    input  logic signed [C_DSIZE-1:0] I_bias,
    input  logic [C_SSIZE-1:0]        I_shift,
    input  logic                      I_relu_en,
    output logic [C_ASIZE-1:0]        O_raddr,
    input  logic signed [C_DSIZE-1:0] I_rdata,
    output logic                      O_busy,
    output logic                      O_done,
    sum_rd_quant_if.master            obuf
);
    localparam int PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    // wide enough to hold fifo_cnt + inflight without overflow
    localparam int CW = $clog2(C_FIFO_DEPTH + 1) + 1;
    localparam int SW = C_DSIZE + 2;
    // room for the rounding constant at the largest shift
    localparam int RW = (SW + 1 > (1 << C_SSIZE) + 1) ? SW + 1 : (1 << C_SSIZE) + 1;
    localparam logic signed [RW-1:0] OMAX = RW'((1 << (C_OSIZE - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, RD, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [C_ASIZE:0]          len_q, icnt, pcnt;
    logic signed [C_DSIZE-1:0] bias_q;
    logic [C_SSIZE-1:0]        shift_q;
    logic                      relu_q;
    logic [C_ASIZE-1:0]        raddr_q;
    logic [C_RD_LAT:0]         tok;
    logic [CW-1:0]             fifo_cnt, inflight;
    logic                      issue, accept, push, pop, credit;
    logic                      last_issue, last_pop;
    logic signed [SW-1:0]      s1;
    logic signed [RW-1:0]      s1x, shv;
    logic [C_OSIZE-1:0]        q_val;
    logic [C_OSIZE-1:0]        fifo_mem [C_FIFO_DEPTH];
    logic [PW-1:0]             wp, rp;

    assign credit     = (fifo_cnt + inflight) < CW'(C_FIFO_DEPTH);
    assign last_issue = (icnt == len_q - 1'b1);
    assign last_pop   = ((pcnt + {{C_ASIZE{1'b0}}, pop}) == len_q);
    assign push       = tok[C_RD_LAT];
    assign pop        = obuf.dv & obuf.rdy;
    assign obuf.dv    = (fifo_cnt != '0);
    assign obuf.dout  = obuf.dv ? fifo_mem[rp] : '0;
    assign O_busy     = (state != IDLE);
    assign O_done     = (state == DONE);
    assign O_raddr    = (state == IDLE) ? '0 :
                        (issue ? icnt[C_ASIZE-1:0] : raddr_q);

    always_ff @(posedge I_clk) begin
        if (I_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (I_start) begin
                    accept    = 1'b1;
                    state_nxt = (I_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (credit) begin
                    issue = 1'b1;
                    if (last_issue) state_nxt = DRAIN;
                end
            end
            DRAIN: if (last_pop) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // run setup, counters, token pipeline and stage 1
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            len_q    <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            icnt     <= '0;
            pcnt     <= '0;
            raddr_q  <= '0;
            tok      <= '0;
            inflight <= '0;
            s1       <= '0;
        end else begin
            if (accept) begin
                len_q   <= I_len;
                bias_q  <= I_bias;
                shift_q <= I_shift;
                relu_q  <= I_relu_en;
                icnt    <= '0;
                pcnt    <= '0;
            end else begin
                if (issue) icnt <= icnt + 1'b1;
                if (pop)   pcnt <= pcnt + 1'b1;
            end
            raddr_q <= O_raddr;
            tok     <= {tok[C_RD_LAT-1:0], issue};
            if (issue && !push)      inflight <= inflight + 1'b1;
            else if (!issue && push) inflight <= inflight - 1'b1;
            s1 <= {{2{I_rdata[C_DSIZE-1]}}, I_rdata}
                + {{2{bias_q[C_DSIZE-1]}}, bias_q};
        end
    end

    // stage 2: shift, ReLU, saturate; result goes straight into the FIFO
    assign s1x = {{(RW - SW){s1[SW-1]}}, s1};

`ifdef SUM_RD_QUANT_ROUND_EN
    logic signed [RW-1:0] rnd;
    assign rnd = (shift_q != '0) ? (RW'(1) << (shift_q - 1'b1)) : '0;
`endif

    always_comb begin
`ifdef SUM_RD_QUANT_ROUND_EN
        shv = (s1x + rnd) >>> shift_q;
`else
        shv = s1x >>> shift_q;
`endif
        if (relu_q && shv[RW-1]) shv = '0;
        if (shv > OMAX)      q_val = OMAX[C_OSIZE-1:0];
        else if (shv < OMIN) q_val = OMIN[C_OSIZE-1:0];
        else                 q_val = shv[C_OSIZE-1:0];
    end

    always_ff @(posedge I_clk) begin
        if (push) fifo_mem[wp] <= q_val;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wp       <= '0;
            rp       <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wp <= (wp == PW'(C_FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)  rp <= (rp == PW'(C_FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_sum_rd_quant.sv
// Directed testbench for sum_rd_quant with a 3-cycle-latency sum RAM model.
// Ports of the DUT are all driven/observed here; the output stream uses sum_rd_quant_if.
module tb_sum_rd_quant;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [10:0]        len = '0;
    logic signed [23:0] bias = '0;
    logic [4:0]         shift = '0;
    logic               relu = 1'b0;
    logic [9:0]         raddr;
    logic signed [23:0] rdata;
    logic               busy, done;

    sum_rd_quant_if #(.C_OSIZE(8)) obuf ();

    sum_rd_quant dut (
        .I_clk     (clk),
        .I_rst     (rst),
        .I_start   (start),
        .I_len     (len),
        .I_bias    (bias),
        .I_shift   (shift),
        .I_relu_en (relu),
        .O_raddr   (raddr),
        .I_rdata   (rdata),
        .O_busy    (busy),
        .O_done    (done),
        .obuf      (obuf.master)
    );

    always #5 clk = ~clk;

    logic signed [23:0] mem [1024];
    logic signed [23:0] d0, d1, d2;
    always @(posedge clk) begin
        d0 <= mem[raddr];
        d1 <= d0;
        d2 <= d1;
    end
    assign rdata = d2;

    logic [7:0] got [$];
    time        pop_t [$];
    time        done_t;
    time        t_start, t_dv;
    int         done_cnt = 0;
    int         dv_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (obuf.dv) dv_cnt++;
            if (obuf.dv && obuf.rdy) begin
                got.push_back(obuf.dout);
                pop_t.push_back($time);
            end
            if (done) begin
                done_cnt++;
                done_t = $time;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag,
                   $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        got.delete();
        pop_t.delete();
        dv_cnt = 0;
    endtask

    task automatic do_start(input int l, input int b, input int s, input bit r);
        tick();
        len     = 11'(l);
        bias    = 24'(b);
        shift   = 5'(s);
        relu    = r;
        start   = 1'b1;
        t_start = $time;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int n;
        n0 = done_cnt;
        n  = 0;
        while (done_cnt == n0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt - n0), 32'd1);
    endtask

    initial begin
        int n;
        int dc;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        obuf.rdy = 1'b1;

        // reset values
        repeat (3) tick();
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_dout", 32'(obuf.dout), 32'd0);
        chk("rst_dv", 32'(obuf.dv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // saturation at both ends, latency, back-to-back output
        mem[0] = 24'sd10;
        mem[1] = -24'sd20;
        mem[2] = 24'sd300;
        mem[3] = -24'sd300;
        clear();
        do_start(4, 0, 0, 1'b0);
        n = 0;
        while (!obuf.dv && n < 20) begin
            tick();
            n++;
        end
        t_dv = $time;
        chk("t1_latency", 32'((t_dv - t_start) / 10), 32'd6);
        wait_done("t1_done", 50);
        chk("t1_count", 32'(got.size()), 32'd4);
        chk8("t1_d0", got[0], 8'd10);
        chk8("t1_d1", got[1], 8'hEC);
        chk8("t1_d2", got[2], 8'h7F);
        chk8("t1_d3", got[3], 8'h80);
        chk("t1_consec", 32'((pop_t[3] - pop_t[0]) / 10), 32'd3);
        chk("t1_done_lat", 32'((done_t - pop_t[3]) / 10), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // negative bias with ReLU
        mem[0] = 24'sd5;
        mem[1] = 24'sd6;
        mem[2] = 24'sd7;
        clear();
        do_start(3, -6, 0, 1'b1);
        wait_done("t2_done", 50);
        chk("t2_count", 32'(got.size()), 32'd3);
        chk8("t2_d0", got[0], 8'd0);
        chk8("t2_d1", got[1], 8'd0);
        chk8("t2_d2", got[2], 8'd1);

        // shift: floor vs round-half-up
        mem[0] = 24'sd13;
        mem[1] = -24'sd13;
        clear();
        do_start(2, 0, 2, 1'b0);
        wait_done("t3_done", 50);
        chk8("t3_d0", got[0], 8'd3);
`ifdef SUM_RD_QUANT_ROUND_EN
        chk8("t3_d1", got[1], 8'hFD);
`else
        chk8("t3_d1", got[1], 8'hFC);
`endif

        // bias + shift with saturation after the shift
        mem[0] = 24'sd1000;
        mem[1] = -24'sd1000;
        clear();
        do_start(2, 24, 3, 1'b0);
        wait_done("t3b_done", 50);
        chk8("t3b_d0", got[0], 8'h7F);
        chk8("t3b_d1", got[1], 8'(-122));

        // credit stall under full backpressure, then 1-in-4 ready
        for (int i = 0; i < 32; i++) mem[i] = 24'(i - 16);
        clear();
        obuf.rdy = 1'b0;
        do_start(32, 0, 0, 1'b0);
        repeat (30) tick();
        chk("t4_stall_addr", 32'(raddr), 32'd7);
        chk("t4_stall_dv", 32'(obuf.dv), 32'd1);
        chk("t4_stall_pops", 32'(got.size()), 32'd0);
        dc = done_cnt;
        n = 0;
        while (done_cnt == dc && n < 600) begin
            obuf.rdy = (n % 4 == 0);
            tick();
            n++;
        end
        obuf.rdy = 1'b1;
        chk("t4_done", 32'(done_cnt - dc), 32'd1);
        chk("t4_count", 32'(got.size()), 32'd32);
        for (int i = 0; i < 32; i++)
            chk8($sformatf("t4_d%0d", i), got[i], 8'(i - 16));

        // len=0 run
        clear();
        dc = done_cnt;
        do_start(0, 0, 0, 1'b0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        tick();
        chk("t5_busy_off", 32'(busy), 32'd0);
        chk("t5_done_off", 32'(done), 32'd0);
        repeat (10) tick();
        chk("t5_no_dv", 32'(dv_cnt), 32'd0);
        chk("t5_one_done", 32'(done_cnt - dc), 32'd1);

        // start while busy is ignored
        clear();
        dc = done_cnt;
        do_start(8, 0, 0, 1'b0);
        repeat (2) tick();
        do_start(2, 100, 0, 1'b0);
        wait_done("t5b_done", 100);
        repeat (20) tick();
        chk("t5b_one_done", 32'(done_cnt - dc), 32'd1);
        chk("t5b_count", 32'(got.size()), 32'd8);
        chk8("t5b_first", got[0], 8'(-16));
        chk8("t5b_last", got[7], 8'(-9));

        // reset mid-run abandons it
        clear();
        do_start(16, 0, 0, 1'b0);
        n = 0;
        while (got.size() < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_reached5", 32'(got.size()), 32'd5);
        rst = 1'b1;
        tick();
        chk("t6_dv", 32'(obuf.dv), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        dc = done_cnt;
        repeat (20) tick();
        chk("t6_no_done", 32'(done_cnt - dc), 32'd0);
        clear();
        do_start(2, 0, 0, 1'b0);
        wait_done("t6b_done", 50);
        chk("t6b_count", 32'(got.size()), 32'd2);
        chk8("t6b_d0", got[0], 8'(-16));
        chk8("t6b_d1", got[1], 8'(-15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sum_rd_quant.md
Name: sum_rd_quant

Overview:
- Downstream stage of the accumulation sum RAM.
- After a layer's accumulation finishes, it reads the stored partial-sum words in ascending address order through the sum RAM read port (read address out, read data in).
- It post-processes each word (bias add, arithmetic right shift, optional ReLU, saturation to output width) and streams the results to the output buffer writer over a valid/ready interface.
- Read issue is credit-throttled, so backpressure never drops data.

Parameters:
C_DSIZE, 24, width of the signed sum word read from the sum RAM
C_ASIZE, 10, sum RAM address width
C_OSIZE, 8, signed output data width
C_SSIZE, 5, shift-amount width
C_RD_LAT, 3, cycles from O_raddr change to matching I_rdata
C_FIFO_DEPTH, 8, output FIFO depth; must be ≥ C_RD_LAT+3

Ports:
I_clk  in  1  clock
I_rst  in  1  reset, synchronous, active-high
I_start  in  1  one-cycle start pulse; ignored while O_busy=1
I_len  in  C_ASIZE+1  number of words to read (0..2^C_ASIZE); sampled at start
I_bias  in  C_DSIZE  signed bias; sampled at start
I_shift  in  C_SSIZE  right-shift amount; sampled at start
I_relu_en  in  1  clamp negatives to 0; sampled at start
O_raddr  out  C_ASIZE  sum RAM read address
I_rdata  in  C_DSIZE  sum RAM read data, valid C_RD_LAT cycles after O_raddr
O_dout  out  C_OSIZE  output word (FIFO head)
O_dv  out  1  output valid
I_rdy  in  1  downstream ready
O_busy  out  1  high from accepted start until done pulse (inclusive)
O_done  out  1  one-cycle pulse once the last word has been popped

Behaviour:
- Reset values: O_raddr=0, O_dout=0, O_dv=0, O_busy=0, O_done=0. Reset also returns the FSM to IDLE, flushes the FIFO, and clears all counters and the in-flight pipeline. Reset mid-operation abandons the run with no done pulse.
- IDLE:
  - On I_start, latch len/bias/shift/relu.
  - If len=0: go to DONE, with no reads issued.
  - Otherwise: go to RD, set issue counter=0.
- RD:
  - Issue a read (O_raddr=issue counter, register an in-flight token) only when fifo_cnt + inflight_cnt < C_FIFO_DEPTH.
  - Increment the issue counter per issued read.
  - After the read of address len-1 is issued, go to DRAIN.
  - Addresses are always 0..len-1; no wrap. len=2^C_ASIZE covers the full RAM.
- Token pipeline: each token is a shift register of depth C_RD_LAT+2. The token enters the FIFO on the cycle its processed data exits stage 2. inflight_cnt counts tokens not yet in the FIFO.
- Datapath (fixed 2-stage after I_rdata arrival):
  - Stage 1: s1 = sext(I_rdata) + sext(bias), C_DSIZE+2 bits.
  - Stage 2: arithmetic shift s1 >>> shift.
    - If relu and result<0, result=0.
    - Saturate to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1] and write to the FIFO.
- FIFO: first-word-fall-through.
  - O_dv = (fifo_cnt != 0); pop when O_dv & I_rdy.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - The credit rule guarantees the FIFO never overflows.
- DRAIN: wait until pop counter == len, then go to DONE.
- DONE: O_done=1 for one cycle, O_busy deasserts the next cycle, go to IDLE.
- O_raddr holds its last value while not issuing and returns to 0 in IDLE.
- Total latency with I_rdy=1: first O_dv 1+C_RD_LAT+2 cycles after the start pulse; throughput 1 word/cycle.

Optional Feature:
SUM_RD_QUANT_ROUND_EN:
- Defined: stage 2 adds 2^(shift-1) to s1 before shifting (round half up) when shift>0; shift=0 is unaffected.
- Not defined: plain arithmetic-shift truncation (floor).
- Pipeline latency is identical in both builds.

Test Plan:
- len=4, RAM words {10,-20,300,-300}, bias=0, shift=0, relu=0, I_rdy=1 -> O_dout 10,-20,127,-128 on consecutive cycles; O_done one cycle after the last pop.
- len=3, words {5,6,7}, bias=-6, shift=0, relu=1 -> outputs 0,0,1.
- Words {13,-13}, bias=0, shift=2 -> without macro 3,-4; with SUM_RD_QUANT_ROUND_EN 3,-3.
- len=32, I_rdy toggling 1-in-4 -> no loss or duplication, outputs in address order; fifo_cnt never exceeds C_FIFO_DEPTH; O_raddr stalls while credit is exhausted.
- len=0 start -> no O_dv, O_busy high 1 cycle, O_done pulse; a second I_start while busy on a len=8 run is ignored.
- I_rst asserted mid-run (after 5 of 16 words) -> next cycle O_dv=0, O_busy=0, no O_done; a new start with len=2 then completes normally.
